instr_fetch_unit: RTL

//  Instruction fetch front end: owns the PC and issues word reads to instruction memory.

---
 rtl/riscv_pkg.sv | 18 +
 rtl/ifu_fifo.sv | 59 +++++
 rtl/instr_fetch_unit.sv | 117 +++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared fetch-side types and constants for the instruction fetch front end.
package riscv_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_DRAIN
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/ifu_fifo.sv
// Synchronous instruction buffer of {instr, pc} entries with flush, occupancy count and empty flag.
module ifu_fifo
    import riscv_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        flush,
    input  logic                        push,
    input  logic                        pop,
    input  logic [$bits(fetch_entry_t)-1:0] wdata,
    output logic [$bits(fetch_entry_t)-1:0] rdata,
    output logic [$clog2(DEPTH):0]      count,
    output logic                        empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned W     = $bits(fetch_entry_t);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             full, do_push, do_pop;

    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            if (do_push && !do_pop)      count_q <= count_q + CNT_ONE;
            else if (do_pop && !do_push) count_q <= count_q - CNT_ONE;
        end
    end

    // Storage needs no reset: entries are only visible while count is non-zero.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: PC, single-outstanding imem requests, buffered hand-off to decode.
// Optional IFU_MISALIGN_CHK_EN: misaligned redirect targets raise fetch_err and are ignored.
module instr_fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        fetch_err
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    fetch_state_e     state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic             req_en_q;
    logic             redirect, req_acc, fifo_push, fifo_pop, fifo_empty;
    logic [31:0]      target;
    logic [CNT_W-1:0] fifo_count;
    fetch_entry_t     push_entry, head;

`ifdef IFU_MISALIGN_CHK_EN
    assign redirect  = br_taken && (br_target[1:0] == 2'b00);
    assign fetch_err = br_taken && (br_target[1:0] != 2'b00);
    assign target    = br_target;
`else
    assign redirect  = br_taken;
    assign fetch_err = 1'b0;
    assign target    = br_target & 32'hFFFF_FFFC;
`endif

    assign req_acc   = imem_req && imem_gnt;
    assign imem_addr = {pc_q[31:2], 2'b00};

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        imem_req  = 1'b0;
        fifo_push = 1'b0;
        unique case (state_q)
            S_REQ: begin
                // Room is reserved for the single outstanding word, so gate on occupancy only.
                imem_req = req_en_q && (fifo_count < FULL_CNT);
                if (req_acc) begin
                    pc_d    = pc_q + 32'd4;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    fifo_push = 1'b1;
                    state_d   = S_REQ;
                end
            end
            S_DRAIN: begin
                if (imem_rvalid) state_d = S_REQ;
            end
            default: state_d = S_REQ;
        endcase
        if (redirect) begin
            pc_d      = target;
            fifo_push = 1'b0;
            if ((state_q == S_REQ && req_acc) || (state_q == S_WAIT && !imem_rvalid)) begin
                state_d = S_DRAIN;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_REQ;
            pc_q     <= RESET_PC;
            req_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_en_q <= 1'b1;
        end
    end

    // The response always belongs to the address just before the advanced pc.
    assign push_entry = '{instr: imem_rdata, pc: pc_q - 32'd4};
    assign fifo_pop   = instr_valid && instr_ready;

    ifu_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (redirect),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .wdata   (push_entry),
        .rdata   (head),
        .count   (fifo_count),
        .empty   (fifo_empty)
    );

    assign instr_valid = !fifo_empty;
    assign instr       = fifo_empty ? NOP_INSTR : head.instr;
    assign instr_pc    = fifo_empty ? 32'h0 : head.pc;

endmodule
